// File: rtl/trace_accumulator.sv
// Sums each trace point over MEASURES sweeps in an internal RAM, then streams
// the accumulated trace out over a valid/ready port once the final sweep lands.
module trace_accumulator #(
    parameter int POINTS   = 2000,
    parameter int MEASURES = 65536,
    parameter int DATA_W   = 14,
    parameter int ACC_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              wrreq,
    input  logic [16:0]       cnt_measure,
    output logic [ACC_W-1:0]  out_data,
    output logic [10:0]       out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overrun
);

    localparam int AW = 11;
    localparam int MW = 17;
    localparam int KW = 12;
    localparam int IW = (POINTS > 1) ? $clog2(POINTS) : 1;
    localparam logic [KW-1:0] K_END  = KW'(POINTS);
    localparam logic [KW-1:0] K_LAST = KW'(POINTS - 1);
    localparam logic [AW-1:0] A_LAST = AW'(POINTS - 1);
    localparam logic [MW-1:0] M_LAST = MW'(MEASURES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DUMP} state_t;

    function automatic logic [ACC_W-1:0] widen(input logic [DATA_W-1:0] s);
        return ACC_W'(s);
    endfunction

    state_t            state_q, state_d;
    logic              wrreq_q;
    logic              sweep_start;
    logic [KW-1:0]     k_q, k_d, k_cur;
    logic [MW-1:0]     sweep_m_q, sweep_m_d, m_cur;
    logic              act_q, act_d, act_cur;
    logic              in_range;
    logic              accept;
    logic              overrun_q;

    logic [ACC_W-1:0]  mem [POINTS];
    logic [IW-1:0]     rd_addr;
    logic [ACC_W-1:0]  ram_q;

    logic              vld_p1_q;
    logic [IW-1:0]     addr_p1_q;
    logic [DATA_W-1:0] data_p1_q;
    logic              first_p1_q;
    logic              last_p1_q;
    logic              fwd_hit_q;
    logic [ACC_W-1:0]  fwd_data_q;
    logic [ACC_W-1:0]  old_p1;
    logic [ACC_W-1:0]  sum_p1;

    logic              wr_en_q;
    logic [IW-1:0]     wr_addr_q;
    logic [ACC_W-1:0]  wr_data_q;
    logic              wr_last_q;

    logic [KW-1:0]     issue_ptr_q, issue_ptr_d;
    logic [IW-1:0]     dptr_q, dptr_d;
    logic              dvld_q, dvld_d;
    logic [IW-1:0]     dump_addr;
    logic              take, advance, more;

    logic [ACC_W-1:0]  out_data_q, out_data_d;
    logic [AW-1:0]     out_addr_q, out_addr_d;
    logic              out_valid_q, out_valid_d;

    assign sweep_start = wrreq && !wrreq_q;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sweep_start && (cnt_measure == '0)) state_d = S_ACCUM;
            S_ACCUM: if (wr_en_q && wr_last_q) state_d = S_DUMP;
            S_DUMP:  if (out_valid_q && out_ready && (out_addr_q == A_LAST)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // A sweep is processed only if it starts while accumulating, or opens a set from IDLE.
    always_comb begin
        k_cur   = sweep_start ? '0 : k_q;
        m_cur   = sweep_start ? cnt_measure : sweep_m_q;
        act_cur = act_q;
        if (sweep_start)
            act_cur = (state_q == S_ACCUM) || ((state_q == S_IDLE) && (cnt_measure == '0));
        in_range  = (k_cur < K_END);
        accept    = wrreq && act_cur && in_range && (state_d == S_ACCUM);
        k_d       = k_cur;
        if (wrreq && in_range)
            k_d = k_cur + KW'(1);
        sweep_m_d = m_cur;
        act_d     = act_cur && (state_d == S_ACCUM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrreq_q   <= 1'b0;
            k_q       <= '0;
            sweep_m_q <= '0;
            act_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wrreq_q   <= wrreq;
            k_q       <= k_d;
            sweep_m_q <= sweep_m_d;
            act_q     <= act_d;
            overrun_q <= overrun_q | (sweep_start && (state_q == S_DUMP));
        end
    end

    assign rd_addr = (state_q == S_DUMP) ? dump_addr : (accept ? k_cur[IW-1:0] : '0);

    always_ff @(posedge clk) begin
        if (wr_en_q)
            mem[wr_addr_q] <= wr_data_q;
        ram_q <= mem[rd_addr];
    end

    // Stage p0 -> p1: address issued, sample and sweep flags travel with it
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            fwd_hit_q <= 1'b0;
        end else begin
            vld_p1_q  <= accept;
            fwd_hit_q <= wr_en_q && (wr_addr_q == rd_addr);
        end
        addr_p1_q  <= k_cur[IW-1:0];
        data_p1_q  <= adc_data;
        first_p1_q <= (m_cur == '0);
        last_p1_q  <= (m_cur == M_LAST) && (k_cur == K_LAST);
        fwd_data_q <= wr_data_q;
    end

    // The RAM word may be stale by one write committed during or right after the read.
    always_comb begin
        old_p1 = ram_q;
        if (fwd_hit_q)
            old_p1 = fwd_data_q;
        if (wr_en_q && (wr_addr_q == addr_p1_q))
            old_p1 = wr_data_q;
        sum_p1 = first_p1_q ? widen(data_p1_q) : old_p1 + widen(data_p1_q);
    end

    // Stage p1 -> p2: sum registered, written to RAM during p2
    always_ff @(posedge clk) begin
        if (rst) wr_en_q <= 1'b0;
        else     wr_en_q <= vld_p1_q;
        wr_addr_q <= addr_p1_q;
        wr_data_q <= sum_p1;
        wr_last_q <= last_p1_q;
    end

    // Dump reads one word ahead; on a stall the same address is re-read so ram_q stays put.
    always_comb begin
        take        = dvld_q && (!out_valid_q || out_ready);
        advance     = take || !dvld_q;
        more        = (issue_ptr_q < K_END);
        issue_ptr_d = issue_ptr_q;
        dptr_d      = dptr_q;
        dvld_d      = dvld_q;
        dump_addr   = dptr_q;
        if (state_q != S_DUMP) begin
            issue_ptr_d = '0;
            dvld_d      = 1'b0;
        end else if (advance) begin
            dvld_d = more;
            if (more) begin
                dump_addr   = issue_ptr_q[IW-1:0];
                dptr_d      = issue_ptr_q[IW-1:0];
                issue_ptr_d = issue_ptr_q + KW'(1);
            end
        end

        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        if ((state_q == S_DUMP) && take) begin
            out_data_d  = ram_q;
            out_addr_d  = AW'(dptr_q);
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_ptr_q <= '0;
            dvld_q      <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            issue_ptr_q <= issue_ptr_d;
            dvld_q      <= dvld_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
        end
        dptr_q <= dptr_d;
    end

    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_trace_accumulator.sv
// Directed bench for trace_accumulator with POINTS=8, MEASURES=4.
module tb_trace_accumulator;

    localparam int NP = 8;
    localparam int NM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] adc_data;
    logic        wrreq;
    logic [16:0] cnt_measure;
    logic [31:0] out_data;
    logic [10:0] out_addr;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        overrun;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] got_d [NP];
    logic [10:0] got_a [NP];
    int          got_c [NP];
    int          n_got;
    int          stall_breaks;
    logic        timed_out;

    trace_accumulator #(
        .POINTS(NP), .MEASURES(NM), .DATA_W(14), .ACC_W(32)
    ) dut (
        .clk(clk), .rst(rst), .adc_data(adc_data), .wrreq(wrreq),
        .cnt_measure(cnt_measure), .out_data(out_data), .out_addr(out_addr),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: constant val; mode 1: 10*m + k
    task automatic send_sweep(input int m, input int mode, input int val);
        cnt_measure = 17'(m);
        for (int k = 0; k <= NP; k++) begin
            wrreq    = 1'b1;
            adc_data = (mode == 1) ? 14'(10 * m + k) : 14'(val);
            tick();
        end
        wrreq = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_set(input int mode, input int val);
        for (int m = 0; m < NM; m++) send_sweep(m, mode, val);
    endtask

    // pat 0: ready always high; pat 1: ready 1,0,0,1 repeating
    task automatic collect_dump(input int pat);
        int          c;
        logic        pv;
        logic [31:0] pd;
        logic [10:0] pa;
        for (int i = 0; i < NP; i++) begin
            got_d[i] = 'x;
            got_a[i] = 'x;
            got_c[i] = -1;
        end
        n_got = 0;
        stall_breaks = 0;
        pv = 1'b0;
        pd = '0;
        pa = '0;
        c = 0;
        while (n_got < NP && c < 300) begin
            out_ready = (pat == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            if (pv && !(out_valid === 1'b1 && out_data === pd && out_addr === pa))
                stall_breaks++;
            if (out_valid === 1'b1 && out_ready) begin
                got_d[n_got] = out_data;
                got_a[n_got] = out_addr;
                got_c[n_got] = c;
                n_got++;
                pv = 1'b0;
            end else if (out_valid === 1'b1) begin
                pv = 1'b1;
                pd = out_data;
                pa = out_addr;
            end else begin
                pv = 1'b0;
            end
            tick();
            c++;
        end
        timed_out = (n_got < NP);
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wrreq = 1'b0;
        adc_data = '0;
        cnt_measure = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        nvec++; if (out_data !== 32'd0) begin nerr++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        nvec++; if (out_addr !== 11'd0) begin nerr++; $display("FAIL reset_out_addr: got %0d want 0", out_addr); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
        nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        rst = 1'b0;
        tick();
        send_sweep(1, 0, 100);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL midset_join_busy: got %b want 0", busy); end
        send_sweep(2, 0, 100);
        send_sweep(3, 0, 100);
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL midset_join_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_constant();
        send_sweep(0, 0, 100);
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL const_busy_rise: got %b want 1", busy); end
        for (int m = 1; m < NM; m++) send_sweep(m, 0, 100);
        collect_dump(0);
        nvec++; if (timed_out !== 1'b0) begin nerr++; $display("FAIL const_timeout: got %0d words want %0d", n_got, NP); end
        for (int i = 0; i < NP; i++) begin
            nvec++; if (got_d[i] !== 32'd400) begin nerr++; $display("FAIL const_data[%0d]: got %0d want 400", i, got_d[i]); end
            nvec++; if (got_a[i] !== 11'(i)) begin nerr++; $display("FAIL const_addr[%0d]: got %0d want %0d", i, got_a[i], i); end
            if (i > 0) begin
                nvec++; if (got_c[i] !== got_c[0] + i) begin nerr++; $display("FAIL const_cycle[%0d]: got %0d want %0d", i, got_c[i], got_c[0] + i); end
            end
        end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL const_busy_fall: got %b want 0", busy); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL const_valid_fall: got %b want 0", out_valid); end
    endtask

    task automatic test_ramp();
        send_set(1, 0);
        collect_dump(0);
        nvec++; if (timed_out !== 1'b0) begin nerr++; $display("FAIL ramp_timeout: got %0d words want %0d", n_got, NP); end
        for (int i = 0; i < NP; i++) begin
            nvec++; if (got_d[i] !== 32'(60 + 4 * i)) begin nerr++; $display("FAIL ramp_data[%0d]: got %0d want %0d", i, got_d[i], 60 + 4 * i); end
            nvec++; if (got_a[i] !== 11'(i)) begin nerr++; $display("FAIL ramp_addr[%0d]: got %0d want %0d", i, got_a[i], i); end
        end
    endtask

    task automatic test_stall();
        send_set(0, 100);
        collect_dump(1);
        nvec++; if (timed_out !== 1'b0) begin nerr++; $display("FAIL stall_timeout: got %0d words want %0d", n_got, NP); end
        nvec++; if (stall_breaks !== 0) begin nerr++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_breaks); end
        for (int i = 0; i < NP; i++) begin
            nvec++; if (got_d[i] !== 32'd400) begin nerr++; $display("FAIL stall_data[%0d]: got %0d want 400", i, got_d[i]); end
            nvec++; if (got_a[i] !== 11'(i)) begin nerr++; $display("FAIL stall_addr[%0d]: got %0d want %0d", i, got_a[i], i); end
        end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL stall_busy_fall: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        send_set(0, 5);
        collect_dump(0);
        for (int i = 0; i < NP; i++) begin
            nvec++; if (got_d[i] !== 32'd20) begin nerr++; $display("FAIL b2b_a_data[%0d]: got %0d want 20", i, got_d[i]); end
        end
        send_set(0, 7);
        collect_dump(0);
        for (int i = 0; i < NP; i++) begin
            nvec++; if (got_d[i] !== 32'd28) begin nerr++; $display("FAIL b2b_b_data[%0d]: got %0d want 28", i, got_d[i]); end
            nvec++; if (got_a[i] !== 11'(i)) begin nerr++; $display("FAIL b2b_b_addr[%0d]: got %0d want %0d", i, got_a[i], i); end
        end
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        send_set(0, 100);
        nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL ovr_before: got %b want 0", overrun); end
        send_sweep(0, 0, 999);
        nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL ovr_set: got %b want 1", overrun); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL ovr_busy: got %b want 1", busy); end
        collect_dump(0);
        for (int i = 0; i < NP; i++) begin
            nvec++; if (got_d[i] !== 32'd400) begin nerr++; $display("FAIL ovr_data[%0d]: got %0d want 400", i, got_d[i]); end
        end
        nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL ovr_sticky_idle: got %b want 1", overrun); end
        send_set(0, 5);
        collect_dump(0);
        for (int i = 0; i < NP; i++) begin
            nvec++; if (got_d[i] !== 32'd20) begin nerr++; $display("FAIL ovr_next_data[%0d]: got %0d want 20", i, got_d[i]); end
        end
        nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL ovr_sticky_end: got %b want 1", overrun); end
    endtask

    task automatic test_rst_mid();
        send_sweep(0, 0, 50);
        send_sweep(1, 0, 50);
        cnt_measure = 17'd2;
        for (int k = 0; k < 4; k++) begin
            wrreq = 1'b1;
            adc_data = 14'd50;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nvec++; if (out_data !== 32'd0) begin nerr++; $display("FAIL rst_out_data: got %0d want 0", out_data); end
        nvec++; if (out_addr !== 11'd0) begin nerr++; $display("FAIL rst_out_addr: got %0d want 0", out_addr); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", busy); end
        nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        for (int k = 4; k <= NP; k++) begin
            wrreq = 1'b1;
            adc_data = 14'd50;
            tick();
        end
        wrreq = 1'b0;
        tick();
        tick();
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_ignore_m2: got busy %b want 0", busy); end
        send_sweep(3, 0, 50);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_ignore_m3: got busy %b want 0", busy); end
        send_set(0, 3);
        collect_dump(0);
        nvec++; if (timed_out !== 1'b0) begin nerr++; $display("FAIL rst_timeout: got %0d words want %0d", n_got, NP); end
        for (int i = 0; i < NP; i++) begin
            nvec++; if (got_d[i] !== 32'd12) begin nerr++; $display("FAIL rst_data[%0d]: got %0d want 12", i, got_d[i]); end
        end
    endtask

    task automatic test_full_scale();
        send_set(0, 16383);
        collect_dump(0);
        for (int i = 0; i < NP; i++) begin
            nvec++; if (got_d[i] !== 32'd65532) begin nerr++; $display("FAIL fullscale_data[%0d]: got %0d want 65532", i, got_d[i]); end
            nvec++; if (got_a[i] !== 11'(i)) begin nerr++; $display("FAIL fullscale_addr[%0d]: got %0d want %0d", i, got_a[i], i); end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_ramp();
        test_stall();
        test_back_to_back();
        test_overrun();
        test_rst_mid();
        test_full_scale();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
